// File: rtl/spi_tx_byte_buffer_pkg.sv
// Shared widths and defaults for the SPI transmit byte path.
// Constants only; no logic.
package spi_tx_pkg;
    localparam int                    SPI_BYTE_W        = 8;
    localparam logic [SPI_BYTE_W-1:0] DEFAULT_FILL_BYTE = 8'hFF;
    localparam int                    DEFAULT_TX_DEPTH  = 16;
endpackage

// File: rtl/spi_tx_byte_buffer_if.sv
// Byte-in / byte-out handshake between the register-read table, the buffer and the shifter.
// master = traffic source/sink side (table + shifter), slave = the buffer.
interface spi_tx_byte_buffer_if;
    logic [spi_tx_pkg::SPI_BYTE_W-1:0] byte_in;
    logic                              byte_in_valid;
    logic                              tx_byte_req;
    logic [spi_tx_pkg::SPI_BYTE_W-1:0] tx_byte;
    logic                              tx_byte_load;

    modport master (
        output byte_in, byte_in_valid, tx_byte_req,
        input  tx_byte, tx_byte_load
    );

    modport slave (
        input  byte_in, byte_in_valid, tx_byte_req,
        output tx_byte, tx_byte_load
    );
endinterface

// File: rtl/spi_tx_byte_buffer_ram.sv
// DEPTH x W storage: synchronous write, combinational read by address.
// Storage is deliberately not reset; occupancy tracking lives in the owner.
module spi_tx_byte_ram #(
    parameter int DEPTH = spi_tx_pkg::DEFAULT_TX_DEPTH,
    parameter int W     = spi_tx_pkg::SPI_BYTE_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/spi_tx_byte_buffer.sv
// Byte FIFO feeding the SPI transmit shifter; one-cycle request-to-load latency, no write backpressure.
// Serves FILL_BYTE on underrun; sticky overflow/underrun flags; flush on request or chip-select fall.
module spi_tx_byte_buffer
    import spi_tx_pkg::*;
#(
    parameter int                    DEPTH       = DEFAULT_TX_DEPTH,
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
    parameter bit                    FLUSH_ON_CS = 1'b1
) (
    input  logic                       sysClk,
    input  logic                       rst,
    spi_tx_byte_buffer_if.slave        bus,
    input  logic                       spi_cs_active,
    input  logic                       flush,
    input  logic                       clear_flags,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       overflow_flag,
    output logic                       underrun_flag
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  cs_q;
    logic [SPI_BYTE_W-1:0] tx_byte_q, tx_byte_d, rd_data;
    logic                  load_q, load_d;
    logic                  flush_now, wr_en, rd_en;

    spi_tx_byte_ram #(.DEPTH(DEPTH), .W(SPI_BYTE_W)) u_ram (
        .clk   (sysClk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (bus.byte_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        flush_now = flush || (FLUSH_ON_CS && cs_q && !spi_cs_active);
        // A read in the same cycle frees a slot, so a write into a full FIFO is still taken.
        wr_en     = bus.byte_in_valid && !flush_now && (!full_q || bus.tx_byte_req);
        rd_en     = bus.tx_byte_req && !empty_q && !flush_now;

        wr_ptr_d  = flush_now ? '0 : wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d  = flush_now ? '0 : rd_ptr_q + PTR_W'(rd_en);
        count_d   = flush_now ? '0 : count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        empty_d   = (count_d == '0);
        full_d    = (count_d == CNT_W'(DEPTH));

        ovf_d = (bus.byte_in_valid && full_q && !bus.tx_byte_req && !flush_now)
              || (ovf_q && !clear_flags);
        unf_d = (bus.tx_byte_req && empty_q && !flush_now)
              || (unf_q && !clear_flags);

        tx_byte_d = tx_byte_q;
        if (bus.tx_byte_req) tx_byte_d = rd_en ? rd_data : FILL_BYTE;
        load_d    = bus.tx_byte_req;
    end

    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cs_q      <= 1'b0;
            tx_byte_q <= FILL_BYTE;
            load_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            cs_q      <= spi_cs_active;
            tx_byte_q <= tx_byte_d;
            load_q    <= load_d;
        end
    end

    assign bus.tx_byte      = tx_byte_q;
    assign bus.tx_byte_load = load_q;
    assign fifo_count       = count_q;
    assign fifo_empty       = empty_q;
    assign fifo_full        = full_q;
    assign overflow_flag    = ovf_q;
    assign underrun_flag    = unf_q;
endmodule

// File: tb/tb_spi_tx_byte_buffer.sv
// Directed bench: two instances (chip-select flush enabled / disabled) share one stimulus stream.
module tb_spi_tx_byte_buffer;
    logic       sysClk = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       vld = 1'b0, req = 1'b0, cs = 1'b1, flush = 1'b0, clr = 1'b0;

    logic [4:0] cnt_a, cnt_b;
    logic       empty_a, full_a, ovf_a, unf_a;
    logic       empty_b, full_b, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;

    spi_tx_byte_buffer_if ifa ();
    spi_tx_byte_buffer_if ifb ();

    assign ifa.byte_in = byte_in;  assign ifb.byte_in = byte_in;
    assign ifa.byte_in_valid = vld; assign ifb.byte_in_valid = vld;
    assign ifa.tx_byte_req = req;  assign ifb.tx_byte_req = req;

    spi_tx_byte_buffer #(.DEPTH(16), .FILL_BYTE(8'hFF), .FLUSH_ON_CS(1'b1)) dut_a (
        .sysClk(sysClk), .rst(rst), .bus(ifa.slave), .spi_cs_active(cs), .flush(flush),
        .clear_flags(clr), .fifo_count(cnt_a), .fifo_empty(empty_a), .fifo_full(full_a),
        .overflow_flag(ovf_a), .underrun_flag(unf_a));

    spi_tx_byte_buffer #(.DEPTH(16), .FILL_BYTE(8'hFF), .FLUSH_ON_CS(1'b0)) dut_b (
        .sysClk(sysClk), .rst(rst), .bus(ifb.slave), .spi_cs_active(cs), .flush(flush),
        .clear_flags(clr), .fifo_count(cnt_b), .fifo_empty(empty_b), .fifo_full(full_b),
        .overflow_flag(ovf_b), .underrun_flag(unf_b));

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       req;
        logic       clr;
        logic       exp_load;
        logic [7:0] exp_byte;
        logic [4:0] exp_cnt;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic c, logic el,
                                logic [7:0] eb, logic [4:0] ec, logic eo, logic eu);
        vec_t t;
        t.vld = v; t.dat = d; t.req = r; t.clr = c;
        t.exp_load = el; t.exp_byte = eb; t.exp_cnt = ec; t.exp_ovf = eo; t.exp_unf = eu;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic chk_a(string tag, logic el, logic [7:0] eb, logic [4:0] ec, logic eo, logic eu);
        chk({tag, ".load"},  ifa.tx_byte_load, el);
        chk({tag, ".byte"},  ifa.tx_byte, eb);
        chk({tag, ".count"}, cnt_a, ec);
        chk({tag, ".empty"}, empty_a, ec == 5'd0);
        chk({tag, ".full"},  full_a, ec == 5'd16);
        chk({tag, ".ovf"},   ovf_a, eo);
        chk({tag, ".unf"},   unf_a, eu);
    endtask

    task automatic idle();
        vld = 1'b0; req = 1'b0; clr = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // Reset, underrun, clear, 4-byte burst, same-cycle write+request on empty, set-beats-clear.
        vecs[0]  = mk(0, 8'h00, 1, 0, 1, 8'hFF, 0, 0, 1);
        vecs[1]  = mk(0, 8'h00, 0, 1, 0, 8'hFF, 0, 0, 0);
        vecs[2]  = mk(1, 8'h78, 0, 0, 0, 8'hFF, 1, 0, 0);
        vecs[3]  = mk(1, 8'h56, 0, 0, 0, 8'hFF, 2, 0, 0);
        vecs[4]  = mk(1, 8'h34, 0, 0, 0, 8'hFF, 3, 0, 0);
        vecs[5]  = mk(1, 8'h12, 0, 0, 0, 8'hFF, 4, 0, 0);
        vecs[6]  = mk(0, 8'h00, 1, 0, 1, 8'h78, 3, 0, 0);
        vecs[7]  = mk(0, 8'h00, 0, 0, 0, 8'h78, 3, 0, 0);
        vecs[8]  = mk(0, 8'h00, 1, 0, 1, 8'h56, 2, 0, 0);
        vecs[9]  = mk(0, 8'h00, 0, 0, 0, 8'h56, 2, 0, 0);
        vecs[10] = mk(0, 8'h00, 1, 0, 1, 8'h34, 1, 0, 0);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 8'h34, 1, 0, 0);
        vecs[12] = mk(0, 8'h00, 1, 0, 1, 8'h12, 0, 0, 0);
        vecs[13] = mk(0, 8'h00, 0, 0, 0, 8'h12, 0, 0, 0);
        vecs[14] = mk(1, 8'h9A, 1, 0, 1, 8'hFF, 1, 0, 1);
        vecs[15] = mk(0, 8'h00, 1, 1, 1, 8'h9A, 0, 0, 0);
        vecs[16] = mk(0, 8'h00, 1, 1, 1, 8'hFF, 0, 0, 1);
        vecs[17] = mk(0, 8'h00, 0, 1, 0, 8'hFF, 0, 0, 0);

        tick();
        chk_a("reset", 1'b0, 8'hFF, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            vld = vecs[i].vld; byte_in = vecs[i].dat; req = vecs[i].req; clr = vecs[i].clr;
            tick();
            chk_a($sformatf("vec%0d", i), vecs[i].exp_load, vecs[i].exp_byte,
                  vecs[i].exp_cnt, vecs[i].exp_ovf, vecs[i].exp_unf);
        end
        idle();

        // 17 writes into a 16-deep FIFO: last byte dropped, overflow set.
        for (int i = 0; i < 17; i++) begin
            vld = 1'b1; byte_in = 8'(i);
            tick();
        end
        idle();
        chk("ovf17.count", cnt_a, 5'd16);
        chk("ovf17.full", full_a, 1'b1);
        chk("ovf17.flag", ovf_a, 1'b1);
        for (int i = 0; i < 16; i++) begin
            req = 1'b1;
            tick();
            chk($sformatf("drain%0d.load", i), ifa.tx_byte_load, 1'b1);
            chk($sformatf("drain%0d.byte", i), ifa.tx_byte, 8'(i));
        end
        idle();
        tick();
        chk("drain.empty", empty_a, 1'b1);
        chk("drain.unf", unf_a, 1'b0);
        clr = 1'b1; tick(); idle();
        chk("ovf.cleared", ovf_a, 1'b0);

        // Full FIFO with simultaneous write and request.
        for (int i = 0; i < 16; i++) begin
            vld = 1'b1; byte_in = 8'h20 + 8'(i);
            tick();
        end
        vld = 1'b1; byte_in = 8'hAA; req = 1'b1;
        tick();
        chk("fullrw.byte", ifa.tx_byte, 8'h20);
        chk("fullrw.count", cnt_a, 5'd16);
        chk("fullrw.ovf", ovf_a, 1'b0);
        vld = 1'b0;
        for (int i = 1; i < 17; i++) begin
            tick();
            chk($sformatf("fullrw.drain%0d", i), ifa.tx_byte, (i == 16) ? 8'hAA : 8'h20 + 8'(i));
        end
        idle();
        tick();
        chk("fullrw.empty", empty_a, 1'b1);

        // Chip-select fall: dut_a flushes, dut_b keeps its bytes.
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1; byte_in = 8'h31 + 8'(i);
            tick();
        end
        idle();
        cs = 1'b0;
        tick();
        chk("csfall.a.count", cnt_a, 5'd0);
        chk("csfall.b.count", cnt_b, 5'd3);
        for (int i = 0; i < 3; i++) begin
            req = 1'b1;
            tick();
            chk($sformatf("csfall.a.byte%0d", i), ifa.tx_byte, 8'hFF);
            chk($sformatf("csfall.b.byte%0d", i), ifb.tx_byte, 8'h31 + 8'(i));
        end
        chk("csfall.a.unf", unf_a, 1'b1);
        chk("csfall.b.unf", unf_b, 1'b0);
        idle();
        cs = 1'b1; clr = 1'b1; tick(); idle();
        chk("csfall.b.empty", empty_b, 1'b1);

        // Explicit flush beats same-cycle write and request.
        vld = 1'b1; byte_in = 8'h44; tick();
        vld = 1'b1; byte_in = 8'h55; req = 1'b1; flush = 1'b1;
        tick(); idle();
        chk_a("flush", 1'b1, 8'hFF, 5'd0, 1'b0, 1'b0);

        // Interleaved write/read across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            vld = 1'b1; byte_in = 8'h60 + 8'(i); req = 1'b0;
            tick();
            chk($sformatf("wrap%0d.count", i), cnt_a, 5'd1);
            vld = 1'b0; req = 1'b1;
            tick();
            chk($sformatf("wrap%0d.byte", i), ifa.tx_byte, 8'h60 + 8'(i));
        end
        idle();
        tick();
        chk_a("wrap.end", 1'b0, 8'h73, 5'd0, 1'b0, 1'b0);

        // Reset mid-burst drops contents.
        vld = 1'b1; byte_in = 8'h01; tick(); tick(); idle();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid.count", cnt_a, 5'd0);
        req = 1'b1; tick(); idle();
        chk_a("rstmid.req", 1'b1, 8'hFF, 5'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_tx_byte_buffer.md
Name: spi_tx_byte_buffer

Overview:
- Byte FIFO between the register-read table (byte_out/byte_out_valid) and the SPI slave transmit shifter.
- Absorbs 4-byte register readout bursts at sysClk rate. Hands one byte to the shifter per request.
- Supplies a fill byte on underrun and keeps sticky overflow/underrun flags for the error register.

Parameters:
- DEPTH, 16, FIFO entries. Must be a power of 2 and at least 4.
- FILL_BYTE, 8'hFF, byte presented when the shifter requests from an empty FIFO.
- FLUSH_ON_CS, 1, when 1, deassertion of spi_cs_active empties the FIFO.

Ports:
- sysClk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  byte from the register-read table.
- byte_in_valid  in  1  byte_in qualifier; one write per high cycle; no backpressure.
- tx_byte_req  in  1  one-cycle pulse from the SPI shifter requesting the next byte; already in the sysClk domain.
- spi_cs_active  in  1  synchronized chip-select active level.
- flush  in  1  synchronous FIFO clear.
- clear_flags  in  1  clears the sticky flags.
- tx_byte  out  8  byte to the shifter; held between loads.
- tx_byte_load  out  1  one-cycle pulse; tx_byte is valid and must be loaded.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- fifo_empty  out  1  fifo_count == 0.
- fifo_full  out  1  fifo_count == DEPTH.
- overflow_flag  out  1  sticky; a write was dropped.
- underrun_flag  out  1  sticky; a fill byte was served.

Behaviour:
- Reset (asynchronous, active-high): pointers and count = 0; tx_byte = FILL_BYTE; tx_byte_load = 0; overflow_flag = 0; underrun_flag = 0; fifo_empty = 1; fifo_full = 0.
- Pointers: $clog2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register; pointers are not compared.
- Write: byte_in_valid with not full stores at wr_ptr; wr_ptr++, count++.
- Write when full: byte dropped; overflow_flag set. The FIFO is unchanged.
- Read latency: tx_byte_req in cycle N gives tx_byte_load = 1 in cycle N+1.
  - Not empty at N: tx_byte = entry at rd_ptr; rd_ptr++, count--.
  - Empty at N: tx_byte = FILL_BYTE; underrun_flag set.
  - There is no write-to-read bypass. A write in the same cycle as a request to an empty FIFO is stored, and the request is served FILL_BYTE.
- Simultaneous read and write:
  - When full: the read frees a slot and the write is accepted; count stays at DEPTH; no overflow.
  - Otherwise: count unchanged.
- tx_byte_req asserted on consecutive cycles: each cycle is a separate request. tx_byte_load stays high for each following cycle.
- Flush sources: flush = 1, or (FLUSH_ON_CS = 1 and spi_cs_active falls 1→0, detected from a registered copy).
  - Pointers and count go to 0 in the next cycle.
  - Flush beats a same-cycle write: the write is discarded and not counted as overflow.
  - Flush beats a same-cycle request: the request is served FILL_BYTE; no underrun.
- clear_flags:
  - Both flags go to 0 in the next cycle.
  - A same-cycle set event wins: the flag stays 1.
- Status outputs (fifo_count, fifo_empty, fifo_full) are registered and consistent with the count at every clock edge.
- Reset mid-burst: all state is lost; the first request after reset is served FILL_BYTE.

Decomposition:
- Shared package spi_tx_pkg holds:
  - SPI_BYTE_W = 8
  - DEFAULT_FILL_BYTE = 8'hFF
  - DEFAULT_TX_DEPTH = 16
- One sub-module, spi_tx_byte_ram: DEPTH×8 storage with a synchronous write port and a combinational read by address. The top level owns the pointers, count, flags and load logic.

Test Plan:
- Reset, then one tx_byte_req → next cycle tx_byte_load = 1, tx_byte = 8'hFF, underrun_flag = 1; clear_flags → 0.
- Write 8'h78, 8'h56, 8'h34, 8'h12 on consecutive cycles, then 4 requests one cycle apart → tx_byte 78, 56, 34, 12 in order, each one cycle after its request; fifo_count goes 4→0.
- Write 17 bytes 8'h00–8'h10 with DEPTH=16 → fifo_full = 1, overflow_flag = 1, byte 8'h10 absent. Drain all 16 → values 00–0F, then fifo_empty = 1.
- With FIFO full, assert byte_in_valid=1 (8'hAA) and tx_byte_req in the same cycle → count stays 16, no overflow; 8'hAA is emitted 16th after draining.
- Load 3 bytes, drop spi_cs_active → next cycle count = 0; following request → 8'hFF with underrun_flag = 1. Repeat with FLUSH_ON_CS = 0 → the 3 bytes are retained and served.
- Wrap check: 40 cycles of interleaved single writes and reads → output sequence equals input sequence across the pointer wrap; no flags set.
